seq_detect_ctrl: RTL and testbench

Run controller for the team's serial-bit Mealy sequence detectors. It accepts a programmable pattern, start/abort commands and a serial bit stream. It detects the pattern, overlapping or not, counts matches and stops after a programmed number of hits. It sits between the register/config interface and the serial input, so a new pattern needs no new detector module.

---
 rtl/seq_detect_pkg.sv | 15 +
 rtl/seq_detect_ctrl_if.sv | 30 +++
 rtl/seq_pattern_matcher.sv | 50 +++++
 rtl/seq_detect_ctrl.sv | 140 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared constants for the serial sequence-detector run controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seq_detect_pkg;

  localparam int PW_DEF = 8;                  // default maximum pattern length
  localparam int CW_DEF = 8;                  // default target / counter width
  localparam int LW_DEF = $clog2(PW_DEF) + 1; // default CFG_LEN width

  // Run-controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: configuration offer bundle (pattern, len, target, overlap).
// Latency: n/a (wires only).
// Backpressure: valid/ready; the slave drops CFG_READY while a run is armed.
// Ports: master drives CFG_VALID/CFG_PATTERN/CFG_LEN/CFG_TARGET/CFG_OVERLAP, slave drives CFG_READY.
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
);
  localparam int LW = $clog2(PW) + 1;

  logic          CFG_VALID;
  logic          CFG_READY;
  logic [PW-1:0] CFG_PATTERN;
  logic [LW-1:0] CFG_LEN;
  logic [CW-1:0] CFG_TARGET;
  logic          CFG_OVERLAP;

  modport master (
    output CFG_VALID, CFG_PATTERN, CFG_LEN, CFG_TARGET, CFG_OVERLAP,
    input  CFG_READY
  );

  modport slave (
    input  CFG_VALID, CFG_PATTERN, CFG_LEN, CFG_TARGET, CFG_OVERLAP,
    output CFG_READY
  );

endinterface

// File: rtl/seq_pattern_matcher.sv
// seq_pattern_matcher: bit history shift register, fill counter and masked pattern compare.
// Latency: match is combinational on the current shift beat.
// Backpressure: none; shifts only when shift_en is high.
// Ports: clk/rst, shift_en + bit_i (serial beat), clear (arm), len/pattern/overlap (config), match (out).
module seq_pattern_matcher #(
  parameter int PW = 8,
  parameter int LW = $clog2(PW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_en,
  input  logic          clear,
  input  logic          bit_i,
  input  logic [LW-1:0] len,
  input  logic [PW-1:0] pattern,
  input  logic          overlap,
  output logic          match
);

  logic [PW-1:0] hist_q, hist_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [LW-1:0] fill_sat;
  logic [LW:0]   fill_inc;
  logic [PW-1:0] mask;

  always_comb begin
    hist_d   = {hist_q[PW-2:0], bit_i};
    // Shifting all-ones left by len leaves ones above the pattern; invert for the low-len mask.
    mask     = ~({PW{1'b1}} << len);
    fill_inc = {1'b0, fill_q} + (LW+1)'(1);
    fill_sat = (fill_inc >= {1'b0, len}) ? len : fill_inc[LW-1:0];
    // fill counts bits that may belong to the next match; it gates stale history after arm/non-overlap hit.
    match    = shift_en && (fill_inc >= {1'b0, len}) && ((hist_d & mask) == (pattern & mask));
    fill_d   = fill_q;
    if (shift_en) begin
      fill_d = (match && !overlap) ? '0 : fill_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run controller for a programmable serial-bit Mealy sequence detector.
// Latency: START to BUSY 1 cycle; match-completing bit to Y 1 cycle.
// Backpressure: CFG_READY low while ARMED; serial bits have no backpressure.
// Ports: CLK/RST, cfg (config valid/ready bundle), START/ABORT commands, I/I_VALID serial input,
//        Y match pulse, MATCH_CNT, BUSY (armed), DONE (target reached).
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  seq_detect_ctrl_if.slave cfg,
  input  logic          START,
  input  logic          ABORT,
  input  logic          I,
  input  logic          I_VALID,
  output logic          Y,
  output logic [CW-1:0] MATCH_CNT,
  output logic          BUSY,
  output logic          DONE
);

  localparam int LW = $clog2(PW) + 1;

  logic [1:0]    state_q, state_d;
  logic          loaded_q, loaded_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [CW-1:0] tgt_q, tgt_d;
  logic          ovl_q, ovl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          y_q, y_d;

  logic          cfg_ready;
  logic          cfg_accept;
  logic          cfg_legal;
  logic          arm;
  logic          shift_en;
  logic          match;
  logic [CW:0]   cnt_inc;

  assign cfg_ready  = (state_q != ST_ARMED);
  assign cfg_accept = cfg.CFG_VALID && cfg_ready;
  assign cfg_legal  = (cfg.CFG_LEN != '0) && (cfg.CFG_LEN <= LW'(PW));
  // ABORT suppresses the beat so an aborted match neither pulses nor counts.
  assign shift_en   = (state_q == ST_ARMED) && I_VALID && !ABORT;
  assign cnt_inc    = {1'b0, cnt_q} + (CW+1)'(1);

  seq_pattern_matcher #(.PW(PW), .LW(LW)) u_matcher (
    .clk      (CLK),
    .rst      (RST),
    .shift_en (shift_en),
    .clear    (arm),
    .bit_i    (I),
    .len      (len_q),
    .pattern  (pat_q),
    .overlap  (ovl_q),
    .match    (match)
  );

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    pat_d    = pat_q;
    len_d    = len_q;
    tgt_d    = tgt_q;
    ovl_d    = ovl_q;
    cnt_d    = cnt_q;
    y_d      = 1'b0;
    arm      = 1'b0;

    // An illegal length still completes the handshake but leaves nothing armable.
    if (cfg_accept) begin
      if (cfg_legal) begin
        pat_d    = cfg.CFG_PATTERN;
        len_d    = cfg.CFG_LEN;
        tgt_d    = cfg.CFG_TARGET;
        ovl_d    = cfg.CFG_OVERLAP;
        loaded_d = 1'b1;
      end else begin
        loaded_d = 1'b0;
      end
    end

    case (state_q)
      ST_ARMED: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (match) begin
          y_d = 1'b1;
          if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_inc[CW-1:0];
          end
          if ((tgt_q != '0) && (cnt_inc == {1'b0, tgt_q})) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        // loaded_d lets a START in the accept cycle use the freshly latched config.
        if (START && loaded_d && !ABORT) begin
          arm     = 1'b1;
          state_d = ST_ARMED;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      loaded_q <= 1'b0;
      pat_q    <= '0;
      len_q    <= '0;
      tgt_q    <= '0;
      ovl_q    <= 1'b0;
      cnt_q    <= '0;
      y_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      tgt_q    <= tgt_d;
      ovl_q    <= ovl_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
    end
  end

  assign Y             = y_q;
  assign MATCH_CNT     = cnt_q;
  assign BUSY          = (state_q == ST_ARMED);
  assign DONE          = (state_q == ST_DONE);
  assign cfg.CFG_READY = cfg_ready;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed plus random stimulus against a queue-based reference model.
module tb_seq_detect_ctrl;

  localparam int PW = 8;
  localparam int CW = 8;
  localparam int LW = $clog2(PW) + 1;

  logic          CLK = 1'b0;
  logic          RST, START, ABORT, I, I_VALID;
  logic          Y, BUSY, DONE;
  logic [CW-1:0] MATCH_CNT;

  int errors = 0;
  int checks = 0;

  seq_detect_ctrl_if #(.PW(PW), .CW(CW)) cfg_if ();

  seq_detect_ctrl #(.PW(PW), .CW(CW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cfg       (cfg_if),
    .START     (START),
    .ABORT     (ABORT),
    .I         (I),
    .I_VALID   (I_VALID),
    .Y         (Y),
    .MATCH_CNT (MATCH_CNT),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  // Reference model: run phase, config, and the bits seen since arming or the last
  // non-overlapping match, kept as a plain queue.
  typedef enum {M_IDLE, M_ARMED, M_DONE} mst_t;
  mst_t          m_st;
  bit            m_loaded;
  bit   [PW-1:0] m_pat;
  int            m_len;
  int            m_tgt;
  bit            m_ovl;
  int            m_cnt;
  bit            m_y;
  bit            win[$];

  function automatic bit model_match();
    int n;
    n = win.size();
    if (n < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (win[n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    int L;
    if (RST) begin
      m_st = M_IDLE; m_loaded = 0; m_pat = '0; m_len = 0; m_tgt = 0;
      m_ovl = 0; m_cnt = 0; m_y = 0; win.delete();
    end else begin
      if (cfg_if.CFG_VALID && (m_st != M_ARMED)) begin
        L = int'(cfg_if.CFG_LEN);
        if (L >= 1 && L <= PW) begin
          m_pat = cfg_if.CFG_PATTERN; m_len = L; m_tgt = int'(cfg_if.CFG_TARGET);
          m_ovl = cfg_if.CFG_OVERLAP; m_loaded = 1;
        end else begin
          m_loaded = 0;
        end
      end
      m_y = 0;
      if (m_st == M_ARMED) begin
        if (ABORT) begin
          m_st = M_IDLE;
        end else if (I_VALID) begin
          win.push_back(I);
          if (win.size() > PW) void'(win.pop_front());
          if (model_match()) begin
            m_y = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (!m_ovl) win.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) m_st = M_DONE;
          end
        end
      end else if (START && m_loaded && !ABORT) begin
        m_st = M_ARMED; m_cnt = 0; win.delete();
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the driven inputs, sample the DUT 1 time unit after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge CLK);
    #1;
    check({tag, ".Y"},     32'(Y),         32'(m_y));
    check({tag, ".CNT"},   32'(MATCH_CNT), 32'(m_cnt));
    check({tag, ".BUSY"},  32'(BUSY),      32'(m_st == M_ARMED));
    check({tag, ".DONE"},  32'(DONE),      32'(m_st == M_DONE));
    check({tag, ".READY"}, 32'(cfg_if.CFG_READY), 32'(m_st != M_ARMED));
    RST = 0; START = 0; ABORT = 0; cfg_if.CFG_VALID = 0;
  endtask

  task automatic offer_cfg(input logic [PW-1:0] pat, input int len, input int tgt, input bit ovl);
    cfg_if.CFG_VALID   = 1'b1;
    cfg_if.CFG_PATTERN = pat;
    cfg_if.CFG_LEN     = LW'(len);
    cfg_if.CFG_TARGET  = CW'(tgt);
    cfg_if.CFG_OVERLAP = ovl;
  endtask

  // Send n bits MSB first; with gaps, a dead cycle (I_VALID=0, I toggled) follows each bit.
  task automatic send_bits(input string tag, input logic [31:0] bits, input int n, input bit gaps);
    logic [31:0] b;
    b = bits;
    for (int i = 0; i < n; i++) begin
      I = b[n - 1 - i]; I_VALID = 1'b1;
      tick(tag);
      if (gaps) begin
        I = ~I; I_VALID = 1'b0;
        tick({tag, "_gap"});
      end
    end
    I_VALID = 1'b0;
  endtask

  initial begin
    RST = 1; START = 0; ABORT = 0; I = 0; I_VALID = 0;
    cfg_if.CFG_VALID = 0; cfg_if.CFG_PATTERN = '0; cfg_if.CFG_LEN = '0;
    cfg_if.CFG_TARGET = '0; cfg_if.CFG_OVERLAP = 0;
    tick("reset");
    check("reset_cnt", 32'(MATCH_CNT), 0);
    check("reset_ready", 32'(cfg_if.CFG_READY), 1);
    tick("idle");

    // 1: overlapping 10011, target 2; config accept and START share a cycle.
    offer_cfg(8'b10011, 5, 2, 1'b1); START = 1;
    tick("t1_arm");
    send_bits("t1", 32'b100110011, 9, 1'b0);
    check("t1_cnt", 32'(MATCH_CNT), 2);
    check("t1_done", 32'(DONE), 1);
    check("t1_busy", 32'(BUSY), 0);

    // 2: same stream, non-overlapping, restart from DONE.
    offer_cfg(8'b10011, 5, 2, 1'b0); START = 1;
    tick("t2_arm");
    send_bits("t2a", 32'b100110011, 9, 1'b0);
    check("t2_cnt1", 32'(MATCH_CNT), 1);
    check("t2_busy", 32'(BUSY), 1);
    send_bits("t2b", 32'b10011, 5, 1'b0);
    check("t2_cnt2", 32'(MATCH_CNT), 2);
    check("t2_done", 32'(DONE), 1);

    // 3: 101 with gaps between valid bits, run until abort.
    offer_cfg(8'b101, 3, 0, 1'b1); START = 1;
    tick("t3_arm");
    send_bits("t3", 32'b101, 3, 1'b1);
    check("t3_cnt", 32'(MATCH_CNT), 1);

    // 4: ABORT on the overlapping match-completing bit.
    I = 0; I_VALID = 1; tick("t4_pre");
    I = 1; I_VALID = 1; ABORT = 1; tick("t4_abort");
    I_VALID = 0;
    check("t4_y", 32'(Y), 0);
    check("t4_cnt", 32'(MATCH_CNT), 1);
    check("t4_ready", 32'(cfg_if.CFG_READY), 1);

    // 5: config offered while armed must not take; illegal lengths disarm.
    offer_cfg(8'b101, 3, 0, 1'b0); START = 1;
    tick("t5_arm");
    offer_cfg(8'b000, 3, 0, 1'b0); I = 1; I_VALID = 1;
    tick("t5_busycfg");
    send_bits("t5", 32'b01, 2, 1'b0);
    check("t5_cnt", 32'(MATCH_CNT), 1);
    ABORT = 1; tick("t5_abort");
    offer_cfg(8'b1, 0, 0, 1'b1); tick("t5_len0");
    START = 1; tick("t5_start_ign");
    check("t5_busy", 32'(BUSY), 0);
    offer_cfg(8'b1, 9, 0, 1'b1); START = 1; tick("t5_len9");
    check("t5_busy9", 32'(BUSY), 0);

    // 6: reset mid-run clears everything including the loaded config.
    offer_cfg(8'b10011, 5, 0, 1'b1); START = 1;
    tick("t6_arm");
    send_bits("t6", 32'b100, 3, 1'b0);
    RST = 1; START = 1; I = 1; I_VALID = 1; tick("t6_rst");
    I_VALID = 0;
    check("t6_busy", 32'(BUSY), 0);
    START = 1; tick("t6_start_ign");
    check("t6_busy2", 32'(BUSY), 0);

    // 7: target 0 with a 1-bit pattern drives the counter into saturation.
    offer_cfg(8'b1, 1, 0, 1'b1); START = 1;
    tick("t7_arm");
    I = 1; I_VALID = 1;
    for (int i = 0; i < 260; i++) tick("t7");
    check("t7_sat", 32'(MATCH_CNT), 255);
    check("t7_y", 32'(Y), 1);
    I_VALID = 0; ABORT = 1; tick("t7_abort");

    // Random phase.
    for (int c = 0; c < 1500; c++) begin
      RST     = ($urandom_range(0, 199) == 0);
      START   = ($urandom_range(0, 7) == 0);
      ABORT   = ($urandom_range(0, 39) == 0);
      I       = 1'($urandom_range(0, 1));
      I_VALID = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        offer_cfg(PW'($urandom()),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
